// File: rtl/dcache_mem.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mem
// Purpose  : Nibble-serial memory front end for a data cache. It turns a
//            line-fill (pull) or dirty-line writeback (push) request into
//            the following sequence of phases, one nibble per cycle:
//            CMD -> ADDR -> [DUMMY] -> RDATA/WDATA -> DONE.
// Ports    :
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   pull       in   line-fill request
//   push       in   writeback request (takes priority over pull)
//   tag        in   line address, PA-$clog2(LINE_LENGTH) bits
//   dwrite     in   writeback nibble from the cache (qualified by rstrobe_d)
//   dread      out  fill nibble to the cache (qualified by wstrobe_d)
//   wstrobe_d  out  fill strobe
//   rstrobe_d  out  writeback strobe
//   busy       out  transaction in progress
//   done       out  one-cycle completion pulse
//   mem_cs_n   out  memory chip select, active-low
//   mem_out    out  nibble driven to memory
//   mem_oe     out  mem_out drive enable
//   mem_in     in   nibble from memory
//   mem_wait   in   memory stall, honoured in CMD/ADDR only
// Revision : 1.0 - initial release
// ============================================================================
module dcache_mem #(
    parameter int         PA          = 22,
    parameter int         LINE_LENGTH = 4,
    parameter int         DUMMY       = 2,
    parameter logic [3:0] CMD_READ    = 4'hB,
    parameter logic [3:0] CMD_WRITE   = 4'h2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pull,
    input  logic                               push,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]  tag,
    input  logic [3:0]                         dwrite,
    output logic [3:0]                         dread,
    output logic                               wstrobe_d,
    output logic                               rstrobe_d,
    output logic                               busy,
    output logic                               done,
    output logic                               mem_cs_n,
    output logic [3:0]                         mem_out,
    output logic                               mem_oe,
    input  logic [3:0]                         mem_in,
    input  logic                               mem_wait
);

    localparam int c_TAG_W = PA - $clog2(LINE_LENGTH);
    localparam int c_NA    = (c_TAG_W + 3) / 4;
    localparam int c_NIB   = 2 * LINE_LENGTH;

    // Counter spans the longest phase; floor of 2 keeps it at least 1 bit wide.
    localparam int c_MAX_A = (c_NA > c_NIB) ? c_NA : c_NIB;
    localparam int c_MAX_B = (c_MAX_A > DUMMY) ? c_MAX_A : DUMMY;
    localparam int c_MAXL  = (c_MAX_B > 2) ? c_MAX_B : 2;
    localparam int c_CW    = $clog2(c_MAXL);

    localparam logic [c_CW-1:0] c_NA_LAST    = c_CW'(c_NA - 1);
    localparam logic [c_CW-1:0] c_NIB_LAST   = c_CW'(c_NIB - 1);
    localparam logic [c_CW-1:0] c_DUMMY_LAST = c_CW'((DUMMY > 0) ? DUMMY - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DUMMY = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_WDATA = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nx;
    logic [c_CW-1:0]      r_cnt;
    logic                 w_adv;
    logic [c_TAG_W-1:0]   r_tag;
    logic                 r_write;
    logic [4*c_NA-1:0]    w_tag_ext;
    logic [c_CW+1:0]      w_shift;
    logic [3:0]           w_addr_nib;

    // ------------------------------------------------------------------------
    // State register, phase counter and request latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tag   <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            // Counter restarts on every phase change, so it never wraps.
            if (w_state_nx != r_state) begin
                r_cnt <= '0;
            end else if (w_adv) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_IDLE) && (push || pull)) begin
                r_tag   <= tag;
                r_write <= push;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_adv      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (push || pull) begin
                    w_state_nx = S_CMD;
                end
            end
            S_CMD: begin
                if (!mem_wait) begin
                    w_state_nx = S_ADDR;
                end
            end
            S_ADDR: begin
                w_adv = !mem_wait;
                if (!mem_wait && (r_cnt == c_NA_LAST)) begin
                    if (r_write) begin
                        w_state_nx = S_WDATA;
                    end else if (DUMMY == 0) begin
                        w_state_nx = S_RDATA;
                    end else begin
                        w_state_nx = S_DUMMY;
                    end
                end
            end
            S_DUMMY: begin
                w_adv = 1'b1;
                if (r_cnt == c_DUMMY_LAST) begin
                    w_state_nx = S_RDATA;
                end
            end
            S_RDATA: begin
                w_adv = 1'b1;
                if (r_cnt == c_NIB_LAST) begin
                    w_state_nx = S_DONE;
                end
            end
            S_WDATA: begin
                w_adv = 1'b1;
                if (r_cnt == c_NIB_LAST) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Address nibble: zero-extended latched tag, MSB nibble first.
    always_comb begin
        w_tag_ext              = '0;
        w_tag_ext[c_TAG_W-1:0] = r_tag;
        w_shift                = {(c_NA_LAST - r_cnt), 2'b00};
        w_addr_nib             = 4'(w_tag_ext >> w_shift);
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        mem_cs_n  = 1'b1;
        mem_oe    = 1'b0;
        mem_out   = 4'h0;
        dread     = 4'h0;
        wstrobe_d = 1'b0;
        rstrobe_d = 1'b0;
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        unique case (r_state)
            S_CMD: begin
                mem_cs_n = 1'b0;
                mem_oe   = 1'b1;
                mem_out  = r_write ? CMD_WRITE : CMD_READ;
            end
            S_ADDR: begin
                mem_cs_n = 1'b0;
                mem_oe   = 1'b1;
                mem_out  = w_addr_nib;
            end
            S_DUMMY: begin
                mem_cs_n = 1'b0;
            end
            S_RDATA: begin
                mem_cs_n  = 1'b0;
                dread     = mem_in;
                wstrobe_d = 1'b1;
            end
            S_WDATA: begin
                // Pass-through so the cache can advance dwrite every cycle.
                mem_cs_n  = 1'b0;
                mem_oe    = 1'b1;
                mem_out   = dwrite;
                rstrobe_d = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_mem
// Purpose  : Directed self-checking bench for dcache_mem at default
//            parameters (20-bit tag, 8 data nibbles, 2 dummy cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        pull;
    logic        push;
    logic [19:0] tag;
    logic [3:0]  dwrite;
    logic [3:0]  dread;
    logic        wstrobe_d;
    logic        rstrobe_d;
    logic        busy;
    logic        done;
    logic        mem_cs_n;
    logic [3:0]  mem_out;
    logic        mem_oe;
    logic [3:0]  mem_in;
    logic        mem_wait;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dcache_mem dut (
        .clk       (clk),
        .reset     (reset),
        .pull      (pull),
        .push      (push),
        .tag       (tag),
        .dwrite    (dwrite),
        .dread     (dread),
        .wstrobe_d (wstrobe_d),
        .rstrobe_d (rstrobe_d),
        .busy      (busy),
        .done      (done),
        .mem_cs_n  (mem_cs_n),
        .mem_out   (mem_out),
        .mem_oe    (mem_oe),
        .mem_in    (mem_in),
        .mem_wait  (mem_wait)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Control bits packed as {cs_n, oe, wstrobe, rstrobe, busy, done}.
    task automatic check_ctl(input string name, input logic [5:0] exp);
        check(name, 32'({mem_cs_n, mem_oe, wstrobe_d, rstrobe_d, busy, done}), 32'(exp));
    endtask

    task automatic check_idle(input string name);
        check_ctl({name, "_ctl"}, 6'b100000);
        check({name, "_out"}, 32'(mem_out), 32'h0);
        check({name, "_dread"}, 32'(dread), 32'h0);
    endtask

    // Runs one transaction starting from IDLE, checking every cycle.
    // wait_nib < 0 disables the address stall; rst_at < 0 disables the abort.
    task automatic do_txn(input bit wr, input bit both, input logic [19:0] t,
                          input int wait_nib, input int wait_len, input bit rd_wait,
                          input bit tag_chg, input bit keep_pull, input int rst_at);
        logic [3:0] exp_nib;
        push = wr;
        pull = !wr || both;
        tag  = t;
        @(negedge clk);
        push = 1'b0;
        pull = keep_pull;
        #1;
        check_ctl("cmd_ctl", 6'b010010);
        check("cmd_nib", 32'(mem_out), wr ? 32'h2 : 32'hB);
        @(negedge clk);
        for (int a = 0; a < 5; a++) begin
            if (tag_chg && a == 1) tag = ~t;
            exp_nib = t[4*(4-a) +: 4];
            if (a == wait_nib) begin
                for (int w = 0; w < wait_len; w++) begin
                    mem_wait = 1'b1;
                    #1;
                    check("addr_hold_nib", 32'(mem_out), 32'(exp_nib));
                    check_ctl("addr_hold_ctl", 6'b010010);
                    @(negedge clk);
                end
                mem_wait = 1'b0;
            end
            #1;
            check("addr_nib", 32'(mem_out), 32'(exp_nib));
            check_ctl("addr_ctl", 6'b010010);
            @(negedge clk);
        end
        if (!wr) begin
            for (int d = 0; d < 2; d++) begin
                #1;
                check_ctl("dummy_ctl", 6'b000010);
                @(negedge clk);
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (!wr) begin
                mem_in   = 4'(k + 1);
                mem_wait = rd_wait && (k >= 2) && (k <= 4);
                if (k == rst_at) reset = 1'b1;
                #1;
                check("rd_dread", 32'(dread), 32'(k + 1));
                check_ctl("rd_ctl", 6'b001010);
            end else begin
                dwrite = 4'(7 - k);
                #1;
                check("wr_out", 32'(mem_out), 32'(7 - k));
                check_ctl("wr_ctl", 6'b010110);
            end
            @(negedge clk);
            if (reset) begin
                reset    = 1'b0;
                mem_wait = 1'b0;
                mem_in   = 4'h0;
                #1;
                check_idle("abort");
                return;
            end
        end
        mem_wait = 1'b0;
        mem_in   = 4'h0;
        dwrite   = 4'h0;
        #1;
        check_ctl("done_ctl", 6'b100011);
        @(negedge clk);
        #1;
        check_idle("post");
    endtask

    initial begin
        reset    = 1'b1;
        pull     = 1'b0;
        push     = 1'b0;
        tag      = 20'h0;
        dwrite   = 4'h0;
        mem_in   = 4'h0;
        mem_wait = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_idle("idle");

        // Basic read and write.
        do_txn(1'b0, 1'b0, 20'hABCDE, -1, 0, 1'b0, 1'b0, 1'b0, -1);
        do_txn(1'b1, 1'b0, 20'h00012, -1, 0, 1'b0, 1'b0, 1'b0, -1);

        // push and pull together: write wins; pull held -> read follows.
        do_txn(1'b1, 1'b1, 20'h12345, -1, 0, 1'b0, 1'b0, 1'b1, -1);
        do_txn(1'b0, 1'b0, 20'h0F0F0, -1, 0, 1'b0, 1'b0, 1'b0, -1);

        // Address stall on 2nd nibble, stall ignored in RDATA, tag changed mid-ADDR.
        do_txn(1'b0, 1'b0, 20'h13579, 1, 3, 1'b1, 1'b1, 1'b0, -1);
        do_txn(1'b1, 1'b0, 20'hC0DE9, 0, 2, 1'b0, 1'b1, 1'b0, -1);

        // Reset on the 4th RDATA cycle, no done afterwards, then a normal read.
        do_txn(1'b0, 1'b0, 20'h2468A, -1, 0, 1'b0, 1'b0, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_idle("after_abort");
        end
        do_txn(1'b0, 1'b0, 20'hFEDCB, -1, 0, 1'b0, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
